// File: rtl/pipe_barrel_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package pipe_barrel_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      LSL = 2'b00,
      LSR = 2'b01,
      ASR = 2'b10,
      ROR = 2'b11
   } shift_op_t;

   // Number of register stages: one per REG_EVERY mux levels, last level always registered.
   function automatic int latency(input int width, input int reg_every);
      int levels;
      levels = $clog2(width);
      return (levels + reg_every - 1) / reg_every;
   endfunction

endpackage

// File: rtl/barrel_level.sv
// One combinational mux level of the barrel shifter: shifts by DIST when enabled
// and folds any bits pushed out by LSR/ASR into the running sticky flag.
module barrel_level
   import pipe_barrel_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] data_in,
   input  shift_op_t        op,
   input  logic             en,
   input  logic             sticky_in,
   output logic [WIDTH-1:0] data_out,
   output logic             sticky_out
);

   // Select the shifted word for this level's distance and accumulate sticky.
   always_comb begin
      data_out   = data_in;
      sticky_out = sticky_in;
      if (en) begin
         case (op)
            LSL: data_out = data_in << DIST;
            LSR: begin
               data_out   = data_in >> DIST;
               sticky_out = sticky_in | (|data_in[DIST-1:0]);
            end
            ASR: begin
               data_out   = $signed(data_in) >>> DIST;
               sticky_out = sticky_in | (|data_in[DIST-1:0]);
            end
            ROR: data_out = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
            default: data_out = data_in;
         endcase
      end
   end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with sticky output and a
// valid/ready stream. A register follows every REG_EVERY mux levels and the
// final level; the whole pipe stalls together when the output is blocked.
module pipe_barrel_shifter
   import pipe_barrel_pkg::*;
#(
   parameter int  WIDTH     = 24,
   parameter int  REG_EVERY = 2,
   parameter int  TAG_W     = 4,
   localparam int SW        = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SW-1:0]    in_amt,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sticky,
   output logic [TAG_W-1:0] out_tag
);

   localparam int LEVELS = SW;
   localparam int LAT    = latency(WIDTH, REG_EVERY);
   localparam logic [SW:0] WIDTH_EXT = (SW+1)'(WIDTH);

   // src_*[k] feeds mux level k; src_*[LEVELS] is the final registered result.
   logic [WIDTH-1:0] src_data   [0:LEVELS];
   shift_op_t        src_op     [0:LEVELS];
   logic [SW-1:0]    src_amt    [0:LEVELS];
   logic             src_sticky [0:LEVELS];
   logic [TAG_W-1:0] src_tag    [0:LEVELS];

   logic [LAT-1:0]   stage_valid;
   logic             advance;
   logic             accept;
   shift_op_t        op_in;
   logic [SW:0]      amt_ext;

   // Global stall: everything moves only when the output slot is free or draining.
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign accept    = in_valid && advance;
   assign out_valid = stage_valid[LAT-1];

   // Input stage: a rotate by amt >= WIDTH equals a rotate by amt-WIDTH, and
   // amt < 2*WIDTH, so one conditional subtract suffices. Shifts keep the raw
   // amount; accumulated distance >= WIDTH naturally flushes every bit.
   assign op_in         = shift_op_t'(in_op);
   assign amt_ext       = {1'b0, in_amt};
   assign src_data[0]   = in_data;
   assign src_op[0]     = op_in;
   assign src_sticky[0] = 1'b0;
   assign src_tag[0]    = in_tag;
   assign src_amt[0]    = (op_in == ROR && amt_ext >= WIDTH_EXT) ?
                          SW'(amt_ext - WIDTH_EXT) : in_amt;

   for (genvar gi = 0; gi < LEVELS; gi++) begin : g_level
      logic [WIDTH-1:0] lvl_data;
      logic             lvl_sticky;

      barrel_level #(
         .WIDTH (WIDTH),
         .DIST  (1 << gi)
      ) u_level (
         .data_in    (src_data[gi]),
         .op         (src_op[gi]),
         .en         (src_amt[gi][gi]),
         .sticky_in  (src_sticky[gi]),
         .data_out   (lvl_data),
         .sticky_out (lvl_sticky)
      );

      if (((gi + 1) % REG_EVERY == 0) || (gi == LEVELS - 1)) begin : g_reg
         localparam int STG = gi / REG_EVERY;

         logic             valid_d;
         logic             valid_reg;
         logic [WIDTH-1:0] data_reg;
         logic             sticky_reg;
         shift_op_t        op_reg;
         logic [SW-1:0]    amt_reg;
         logic [TAG_W-1:0] tag_reg;

         if (STG == 0) begin : g_first
            assign valid_d = accept;
         end else begin : g_next
            assign valid_d = stage_valid[STG-1];
         end

         // Pipeline register: loads the whole beat on advance, holds on stall.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_reg  <= 1'b0;
               data_reg   <= '0;
               sticky_reg <= 1'b0;
               op_reg     <= LSL;
               amt_reg    <= '0;
               tag_reg    <= '0;
            end else if (advance) begin
               valid_reg  <= valid_d;
               data_reg   <= lvl_data;
               sticky_reg <= lvl_sticky;
               op_reg     <= src_op[gi];
               amt_reg    <= src_amt[gi];
               tag_reg    <= src_tag[gi];
            end
         end

         assign stage_valid[STG] = valid_reg;
         assign src_data[gi+1]   = data_reg;
         assign src_sticky[gi+1] = sticky_reg;
         assign src_op[gi+1]     = op_reg;
         assign src_amt[gi+1]    = amt_reg;
         assign src_tag[gi+1]    = tag_reg;
      end else begin : g_comb
         assign src_data[gi+1]   = lvl_data;
         assign src_sticky[gi+1] = lvl_sticky;
         assign src_op[gi+1]     = src_op[gi];
         assign src_amt[gi+1]    = src_amt[gi];
         assign src_tag[gi+1]    = src_tag[gi];
      end
   end

   assign out_data   = src_data[LEVELS];
   assign out_sticky = src_sticky[LEVELS];
   assign out_tag    = src_tag[LEVELS];

   // Op and amount are carried into the last register for uniformity but not consumed.
   logic unused_tail;
   assign unused_tail = ^{src_op[LEVELS], src_amt[LEVELS]};

endmodule
